// File: rtl/ram_sweep_if.sv
// ram_sweep bus: strobe/ready/ack access handshake plus clear/busy sweep control.
// master = CPU memory state machine side, slave = ram_sweep side.
interface ram_sweep_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9
);
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  write_enable;
   logic                  strobe;
   logic                  clear;
   logic                  ready;
   logic                  ack;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  busy;

   modport master (
      output address, data_in, write_enable, strobe, clear,
      input  ready, ack, data_out, busy
   );

   modport slave (
      input  address, data_in, write_enable, strobe, clear,
      output ready, ack, data_out, busy
   );
endinterface

// File: rtl/ram_sweep.sv
// Synchronous RAM with handshake, optional wait states and a hardware fill sweep.
// Ports: raw_clk, reset (async, active-high), bus (ram_sweep_if.slave).
module ram_sweep #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 9,
   parameter int                    DEPTH       = 512,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE  = '0,
   parameter int                    WAIT_STATES = 0
) (
   input  logic  raw_clk,
   input  logic  reset,
   ram_sweep_if.slave bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {INIT, IDLE, WAIT} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      sweep_q, sweep_d;
   logic [3:0]            wait_q, wait_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic                  we_q, we_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  mem_we;
   logic [IDX_W-1:0]      mem_idx;
   logic [DATA_WIDTH-1:0] mem_wdat;

   logic                  accept;
   logic                  acc;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdat;
   logic                  acc_we;
   logic                  in_range;

   always_comb begin
      state_d  = state_q;
      sweep_d  = sweep_q;
      wait_d   = wait_q;
      ack_d    = 1'b0;
      dout_d   = dout_q;
      addr_d   = addr_q;
      wdat_d   = wdat_q;
      we_d     = we_q;
      acc      = 1'b0;
      acc_addr = bus.address;
      acc_wdat = bus.data_in;
      acc_we   = bus.write_enable;
      mem_we   = 1'b0;
      mem_idx  = sweep_q;
      mem_wdat = FILL_VALUE;
      accept   = bus.strobe & (state_q == IDLE) & ~bus.clear;

      unique case (state_q)
         INIT: begin
            mem_we  = 1'b1;
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST) begin
               state_d = IDLE;
               sweep_d = '0;
            end
         end
         IDLE: begin
            if (bus.clear) begin
               state_d = INIT;
               sweep_d = '0;
            end else if (accept) begin
               if (WAIT_STATES == 0) begin
                  acc = 1'b1;
               end else begin
                  state_d = WAIT;
                  wait_d  = WS;
                  addr_d  = bus.address;
                  wdat_d  = bus.data_in;
                  we_d    = bus.write_enable;
               end
            end
         end
         WAIT: begin
            // clear aborts the pending access, even on its final cycle
            if (bus.clear) begin
               state_d = INIT;
               sweep_d = '0;
            end else if (wait_q == 4'd1) begin
               acc      = 1'b1;
               acc_addr = addr_q;
               acc_wdat = wdat_q;
               acc_we   = we_q;
               state_d  = IDLE;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         default: state_d = INIT;
      endcase

      // out-of-range words do not alias onto implemented ones
      in_range = {1'b0, acc_addr} < DEPTH_X;

      if (acc) begin
         ack_d = 1'b1;
         if (acc_we) begin
            mem_we   = in_range;
            mem_idx  = acc_addr[IDX_W-1:0];
            mem_wdat = acc_wdat;
         end else begin
            dout_d = in_range ? mem[acc_addr[IDX_W-1:0]] : FILL_VALUE;
         end
      end
   end

   always_ff @(posedge raw_clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         sweep_q <= '0;
         wait_q  <= '0;
         ack_q   <= 1'b0;
         dout_q  <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         wait_q  <= wait_d;
         ack_q   <= ack_d;
         dout_q  <= dout_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         we_q    <= we_d;
      end
   end

   // storage has no reset; the sweep initialises it
   always_ff @(posedge raw_clk) begin
      if (mem_we) mem[mem_idx] <= mem_wdat;
   end

   assign bus.ready    = (state_q == IDLE);
   assign bus.busy     = (state_q == INIT);
   assign bus.ack      = ack_q;
   assign bus.data_out = dout_q;
endmodule

// File: tb/tb_ram_sweep.sv
// Directed bench for ram_sweep: three instances (0, 2 and 3 wait states).
// Covers sweep length, handshake timing, range limit, clear and reset abort.
module tb_ram_sweep;
   logic raw_clk = 1'b0;
   always #5 raw_clk = ~raw_clk;

   logic rst_a, rst_b, rst_c;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct packed {
      logic       busy;
      logic       ready;
      logic       ack;
      logic [7:0] dout;
   } obs_t;

   ram_sweep_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) ia ();
   ram_sweep_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) ib ();
   ram_sweep_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) ic ();

   ram_sweep #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .DEPTH(64),
               .FILL_VALUE(8'h00), .WAIT_STATES(0))
   u_a (.raw_clk(raw_clk), .reset(rst_a), .bus(ia.slave));

   ram_sweep #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .DEPTH(64),
               .FILL_VALUE(8'hEE), .WAIT_STATES(2))
   u_b (.raw_clk(raw_clk), .reset(rst_b), .bus(ib.slave));

   ram_sweep #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .DEPTH(64),
               .FILL_VALUE(8'h00), .WAIT_STATES(3))
   u_c (.raw_clk(raw_clk), .reset(rst_c), .bus(ic.slave));

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic obs_t obs(input int d);
      obs_t o;
      case (d)
         0:       o = {ia.busy, ia.ready, ia.ack, ia.data_out};
         1:       o = {ib.busy, ib.ready, ib.ack, ib.data_out};
         default: o = {ic.busy, ic.ready, ic.ack, ic.data_out};
      endcase
      return o;
   endfunction

   task automatic drive(input int d, input logic stb, input logic clr,
                        input logic we, input logic [8:0] a,
                        input logic [7:0] wd);
      case (d)
         0: begin
            ia.strobe = stb; ia.clear = clr; ia.write_enable = we;
            ia.address = a; ia.data_in = wd;
         end
         1: begin
            ib.strobe = stb; ib.clear = clr; ib.write_enable = we;
            ib.address = a; ib.data_in = wd;
         end
         default: begin
            ic.strobe = stb; ic.clear = clr; ic.write_enable = we;
            ic.address = a; ic.data_in = wd;
         end
      endcase
   endtask

   task automatic step();
      @(posedge raw_clk);
      @(negedge raw_clk);
   endtask

   // single strobe from a negedge; returns data and strobe-to-ack cycles
   task automatic access(input int d, input logic we, input logic [8:0] a,
                         input logic [7:0] wd, output logic [7:0] rd,
                         output int lat);
      obs_t o;
      drive(d, 1'b1, 1'b0, we, a, wd);
      step();
      lat = 1;
      drive(d, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
      o = obs(d);
      while (!o.ack && lat < 40) begin
         step();
         lat++;
         o = obs(d);
      end
      rd = o.dout;
   endtask

   // edges until busy drops, plus any ack seen meanwhile
   task automatic sweep_len(input int d, output int n, output int na);
      obs_t o;
      n  = 0;
      na = 0;
      o  = obs(d);
      while (o.busy && n < 300) begin
         step();
         n++;
         o = obs(d);
         if (o.ack && o.busy) na++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   logic       we_v [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [8:0] a_v  [6] = '{9'd3, 9'd4, 9'd3, 9'd4, 9'd10, 9'd10};
   logic [7:0] d_v  [6] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h3C, 8'h00};
   logic [7:0] e_v  [6] = '{8'h00, 8'h00, 8'hA5, 8'h5A, 8'h5A, 8'h3C};
   int         ra   [3] = '{0, 31, 63};

   initial begin
      obs_t       o;
      logic [7:0] rd;
      int         lat, n, na;

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
      step();
      step();

      o = obs(0);
      chk("rst_busy", o.busy, 1);
      chk("rst_ready", o.ready, 0);
      chk("rst_ack", o.ack, 0);
      chk("rst_dout", o.dout, 0);

      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      sweep_len(0, n, na);
      chk("sweep_len", n, 64);
      chk("sweep_ack", na, 0);
      o = obs(0);
      chk("sweep_ready", o.ready, 1);
      o = obs(1);
      chk("sweep_b_idle", {o.busy, o.ready}, 2'b01);
      o = obs(2);
      chk("sweep_c_idle", {o.busy, o.ready}, 2'b01);

      // zero wait states: fill reads
      for (int i = 0; i < 3; i++) begin
         access(0, 1'b0, 9'(ra[i]), 8'd0, rd, lat);
         chk("fill_rd_lat", lat, 1);
         chk("fill_rd", rd, 8'h00);
      end

      // back-to-back writes/reads, one ack per cycle
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) begin
            o = obs(0);
            chk("b2b_ack", o.ack, 1);
            chk("b2b_ready", o.ready, 1);
            chk("b2b_dout", o.dout, e_v[k-1]);
         end
         if (k < 6) drive(0, 1'b1, 1'b0, we_v[k], a_v[k], d_v[k]);
         else drive(0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
         step();
      end
      o = obs(0);
      chk("b2b_end_ack", o.ack, 0);
      chk("b2b_end_dout", o.dout, 8'h3C);

      // clear beats a simultaneous strobe
      access(0, 1'b1, 9'd5, 8'h12, rd, lat);
      access(0, 1'b0, 9'd5, 8'h00, rd, lat);
      chk("pre_clr_rd", rd, 8'h12);
      drive(0, 1'b1, 1'b1, 1'b1, 9'd5, 8'h77);
      step();
      drive(0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
      o = obs(0);
      chk("clr_ack", o.ack, 0);
      chk("clr_busy", o.busy, 1);
      sweep_len(0, n, na);
      chk("clr_sweep_len", n, 64);
      chk("clr_sweep_ack", na, 0);
      access(0, 1'b0, 9'd5, 8'h00, rd, lat);
      chk("clr_rd_lat", lat, 1);
      chk("clr_rd", rd, 8'h00);

      // two wait states
      access(1, 1'b1, 9'd3, 8'hA5, rd, lat);
      chk("ws2_wr_lat", lat, 3);
      drive(1, 1'b1, 1'b0, 1'b0, 9'd3, 8'h00);
      step();
      o = obs(1);
      chk("ws2_c1", {o.ready, o.ack}, 2'b00);
      step();
      o = obs(1);
      chk("ws2_c2", {o.ready, o.ack}, 2'b00);
      step();
      o = obs(1);
      chk("ws2_c3", {o.ready, o.ack}, 2'b11);
      chk("ws2_rd", o.dout, 8'hA5);
      drive(1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
      na = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         o = obs(1);
         if (o.ack) na++;
      end
      chk("ws2_no_double", na, 0);

      // out of range: write dropped, read gives fill, no aliasing
      access(1, 1'b1, 9'd100, 8'h11, rd, lat);
      chk("oor_wr_lat", lat, 3);
      chk("oor_wr_hold", rd, 8'hA5);
      access(1, 1'b0, 9'd100, 8'h00, rd, lat);
      chk("oor_rd_lat", lat, 3);
      chk("oor_rd", rd, 8'hEE);
      access(1, 1'b0, 9'd36, 8'h00, rd, lat);
      chk("alias_rd", rd, 8'hEE);

      // clear during WAIT aborts the access
      access(1, 1'b1, 9'd9, 8'h44, rd, lat);
      access(1, 1'b0, 9'd9, 8'h00, rd, lat);
      chk("ws2_rd9", rd, 8'h44);
      drive(1, 1'b1, 1'b0, 1'b0, 9'd3, 8'h00);
      step();
      drive(1, 1'b0, 1'b1, 1'b0, 9'd0, 8'd0);
      step();
      drive(1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
      o = obs(1);
      chk("wclr_ack", o.ack, 0);
      chk("wclr_busy", o.busy, 1);
      chk("wclr_dout", o.dout, 8'h44);
      sweep_len(1, n, na);
      chk("wclr_sweep_len", n, 64);
      chk("wclr_sweep_ack", na, 0);
      chk("wclr_dout2", obs(1).dout, 8'h44);
      access(1, 1'b0, 9'd9, 8'h00, rd, lat);
      chk("wclr_rd9", rd, 8'hEE);

      // three wait states, reset mid-WAIT
      access(2, 1'b1, 9'd2, 8'h21, rd, lat);
      chk("ws3_wr_lat", lat, 4);
      access(2, 1'b0, 9'd2, 8'h00, rd, lat);
      chk("ws3_rd_lat", lat, 4);
      chk("ws3_rd", rd, 8'h21);
      drive(2, 1'b1, 1'b0, 1'b1, 9'd7, 8'h99);
      step();
      drive(2, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
      o = obs(2);
      chk("ws3_wait_ready", o.ready, 0);
      step();
      rst_c = 1'b1;
      #1;
      o = obs(2);
      chk("mrst_busy", o.busy, 1);
      chk("mrst_ack", o.ack, 0);
      chk("mrst_dout", o.dout, 8'h00);
      @(negedge raw_clk);
      rst_c = 1'b0;
      sweep_len(2, n, na);
      chk("mrst_sweep_len", n, 64);
      chk("mrst_sweep_ack", na, 0);
      access(2, 1'b0, 9'd7, 8'h00, rd, lat);
      chk("mrst_rd7_lat", lat, 4);
      chk("mrst_rd7", rd, 8'h00);
      access(2, 1'b0, 9'd2, 8'h00, rd, lat);
      chk("mrst_rd2", rd, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
